// File: rtl/player_pos_ctl_multi.sv
// N-channel player x-position controller: per-frame accelerated motion clamped to screen bounds,
// with per-channel respawn and a global freeze. All frame updates commit on the vsync rising edge.
module player_pos_ctl_multi #(
  parameter int N_PLAYERS    = 2,
  parameter int XW           = 12,
  parameter int X_MIN        = 0,
  parameter int X_MAX        = 736,
  parameter int X_INIT0      = 100,
  parameter int X_SPACING    = 400,
  parameter int STEP_MAX     = 8,
  parameter int ACCEL_FRAMES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    v_tick,
  input  logic                    enable,
  input  logic [N_PLAYERS-1:0]    left,
  input  logic [N_PLAYERS-1:0]    right,
  input  logic [N_PLAYERS-1:0]    respawn,
  output logic [N_PLAYERS*XW-1:0] xpos,
  output logic [N_PLAYERS-1:0]    moving,
  output logic [N_PLAYERS-1:0]    at_wall
);

  localparam int SW = $clog2(STEP_MAX + 1);
  // one spare count value so the increment can never wrap before it is compared
  localparam int CW = $clog2(ACCEL_FRAMES + 2);

  localparam logic [XW:0]   XMIN_E  = (XW+1)'(X_MIN);
  localparam logic [XW:0]   XMAX_E  = (XW+1)'(X_MAX);
  localparam logic [SW-1:0] SMAX    = SW'(STEP_MAX);
  localparam logic [SW-1:0] SONE    = SW'(1);
  localparam logic [CW-1:0] CACCEL  = CW'(ACCEL_FRAMES);

  typedef enum logic [1:0] {IDLE, MOVE_L, MOVE_R} state_t;

  if (!(X_MIN < X_MAX && X_MAX < (1 << XW))) begin : g_bad_range
    $fatal(1, "player_pos_ctl_multi: X_MIN < X_MAX < 2**XW violated");
  end
  if (STEP_MAX < 1 || ACCEL_FRAMES < 1) begin : g_bad_speed
    $fatal(1, "player_pos_ctl_multi: STEP_MAX and ACCEL_FRAMES must be >= 1");
  end
  if (N_PLAYERS < 1 || N_PLAYERS > 8) begin : g_bad_count
    $fatal(1, "player_pos_ctl_multi: N_PLAYERS must be 1..8");
  end

  logic v_tick_d_reg;
  logic tick;

  always_ff @(posedge clk) begin
    if (!rst) v_tick_d_reg <= 1'b0;
    else      v_tick_d_reg <= v_tick;
  end

  assign tick = v_tick & ~v_tick_d_reg;

  for (genvar gi = 0; gi < N_PLAYERS; gi++) begin : g_ch
    localparam int INIT_X = X_INIT0 + gi * X_SPACING;
    localparam logic [XW-1:0] INIT_XV = XW'(INIT_X);
    localparam logic INIT_WALL = (INIT_X == X_MIN) || (INIT_X == X_MAX);

    if (INIT_X < X_MIN || INIT_X > X_MAX) begin : g_bad_init
      $fatal(1, "player_pos_ctl_multi: initial x of a channel outside [X_MIN, X_MAX]");
    end

    state_t        state_reg, state_next;
    logic [XW-1:0] x_reg, x_next;
    logic [SW-1:0] speed_reg, speed_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          moving_reg, at_wall_reg;
    state_t        req;
    logic [SW-1:0] step;
    logic [XW:0]   x_ext, sum_r, lim_l;
    logic          clamp;

    always_ff @(posedge clk) begin
      if (!rst) begin
        state_reg   <= IDLE;
        x_reg       <= INIT_XV;
        speed_reg   <= SONE;
        cnt_reg     <= '0;
        moving_reg  <= 1'b0;
        at_wall_reg <= INIT_WALL;
      end else begin
        state_reg   <= state_next;
        x_reg       <= x_next;
        speed_reg   <= speed_next;
        cnt_reg     <= cnt_next;
        moving_reg  <= (state_next == MOVE_L) || (state_next == MOVE_R);
        at_wall_reg <= ((XW+1)'(x_next) == XMIN_E) || ((XW+1)'(x_next) == XMAX_E);
      end
    end

    always_comb begin
      state_next = state_reg;
      x_next     = x_reg;
      speed_next = speed_reg;
      cnt_next   = cnt_reg;
      step       = SONE;
      clamp      = 1'b0;
      x_ext      = (XW+1)'(x_reg);
      sum_r      = '0;
      lim_l      = '0;

      if (left[gi] && !right[gi])      req = MOVE_L;
      else if (right[gi] && !left[gi]) req = MOVE_R;
      else                             req = IDLE;

      if (respawn[gi]) begin
        state_next = IDLE;
        x_next     = INIT_XV;
        speed_next = SONE;
        cnt_next   = '0;
      end else if (tick) begin
        if (!enable || req == IDLE) begin
          state_next = IDLE;
          speed_next = SONE;
          cnt_next   = '0;
        end else begin
          state_next = req;
          if (state_reg != req) begin
            step       = SONE;
            speed_next = SONE;
            cnt_next   = CW'(1);
          end else begin
            // current speed applies to this tick; any increment takes effect next tick
            step = speed_reg;
            if (cnt_reg + CW'(1) == CACCEL) begin
              speed_next = (speed_reg >= SMAX) ? SMAX : speed_reg + SONE;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt_reg + CW'(1);
            end
          end

          if (req == MOVE_R) begin
            sum_r = x_ext + (XW+1)'(step);
            if (sum_r > XMAX_E) begin
              x_next = XMAX_E[XW-1:0];
              clamp  = 1'b1;
            end else begin
              x_next = sum_r[XW-1:0];
            end
          end else begin
            lim_l = XMIN_E + (XW+1)'(step);
            if (x_ext < lim_l) begin
              x_next = XMIN_E[XW-1:0];
              clamp  = 1'b1;
            end else begin
              x_next = x_reg - XW'(step);
            end
          end

          if (clamp) begin
            speed_next = SONE;
            cnt_next   = '0;
          end
        end
      end
    end

    assign xpos[gi*XW +: XW] = x_reg;
    assign moving[gi]        = moving_reg;
    assign at_wall[gi]       = at_wall_reg;
  end

endmodule

// File: tb/tb_player_pos_ctl_multi.sv
// Directed bench for player_pos_ctl_multi with default parameters (2 channels, 0..736 screen).
module tb_player_pos_ctl_multi;

  localparam int XW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          v_tick;
  logic          enable;
  logic [1:0]    left;
  logic [1:0]    right;
  logic [1:0]    respawn;
  logic [2*XW-1:0] xpos;
  logic [1:0]    moving;
  logic [1:0]    at_wall;

  int checks   = 0;
  int failures = 0;

  player_pos_ctl_multi dut (
    .clk     (clk),
    .rst     (rst),
    .v_tick  (v_tick),
    .enable  (enable),
    .left    (left),
    .right   (right),
    .respawn (respawn),
    .xpos    (xpos),
    .moving  (moving),
    .at_wall (at_wall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  // one vsync pulse: level high for 'hold' clocks, then low for one clock
  task automatic frame(input int hold);
    @(negedge clk);
    v_tick = 1'b1;
    repeat (hold) @(negedge clk);
    v_tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic frames(input int n);
    for (int k = 0; k < n; k++) frame(1);
  endtask

  function automatic logic [31:0] x0();
    return 32'(xpos[0 +: XW]);
  endfunction

  function automatic logic [31:0] x1();
    return 32'(xpos[XW +: XW]);
  endfunction

  initial begin
    #1ms;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; v_tick = 1'b0; enable = 1'b1;
    left = 2'b00; right = 2'b00; respawn = 2'b00;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("reset_x0", x0(), 100);
    check("reset_x1", x1(), 500);
    check("reset_moving", 32'(moving), 0);
    check("reset_at_wall", 32'(at_wall), 0);

    // acceleration: 4 ticks at 1 px, 4 at 2 px; one long pulse counts once
    right = 2'b01;
    frames(4);
    check("accel_x0_4", x0(), 104);
    frames(3);
    frame(1000);
    check("accel_x0_8", x0(), 112);
    check("accel_moving0", 32'(moving[0]), 1);
    check("accel_x1_hold", x1(), 500);

    // channel 1 left 40 frames: 4*(1+..+7) + 12*8 = 208 px
    right = 2'b00; left = 2'b10;
    frames(40);
    check("left40_x1", x1(), 292);
    check("left40_moving", 32'(moving), 2);
    check("left40_x0_idle", x0(), 112);
    left = 2'b00; right = 2'b10;
    frame(1);
    check("reverse_x1", x1(), 293);

    // reset mid-motion
    right = 2'b01;
    frame(1);
    check("premrst_x0", x0(), 113);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_x0", x0(), 100);
    check("midrst_x1", x1(), 500);
    check("midrst_moving", 32'(moving), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // right wall: long run clamps at 736 and holds
    right = 2'b01;
    frames(100);
    check("rwall_x0", x0(), 736);
    check("rwall_at_wall", 32'(at_wall), 1);
    check("rwall_x1", x1(), 500);
    right = 2'b00; left = 2'b01;
    frames(12);
    check("rwall_back_x0", x0(), 712);
    check("rwall_back_at_wall", 32'(at_wall[0]), 0);
    left = 2'b00; frame(1);
    left = 2'b01; frames(2);
    left = 2'b00; frame(1);
    right = 2'b01;
    frames(12);
    check("rwall_734", x0(), 734);
    frame(1);
    check("rwall_clamp_x0", x0(), 736);
    check("rwall_clamp_wall", 32'(at_wall[0]), 1);
    frame(1);
    check("rwall_nowrap", x0(), 736);

    // left wall: reach x=3 at speed 5, then clamp to 0
    right = 2'b00;
    @(negedge clk); respawn = 2'b01;
    @(negedge clk); respawn = 2'b00;
    check("respawn_x0", x0(), 100);
    check("respawn_moving0", 32'(moving[0]), 0);
    left = 2'b01; frames(19);
    check("lwall_45", x0(), 45);
    left = 2'b00; frame(1);
    left = 2'b01; frames(2);
    left = 2'b00; frame(1);
    left = 2'b01; frames(16);
    check("lwall_3", x0(), 3);
    frame(1);
    check("lwall_clamp_x0", x0(), 0);
    check("lwall_clamp_wall", 32'(at_wall[0]), 1);
    frame(1);
    check("lwall_nowrap", x0(), 0);

    // both directions: no motion
    left = 2'b00;
    @(negedge clk); respawn = 2'b01;
    @(negedge clk); respawn = 2'b00;
    left = 2'b01; right = 2'b01;
    frame(1);
    check("both_x0", x0(), 100);
    check("both_moving0", 32'(moving[0]), 0);

    // freeze during held right, restart at 1 px
    left = 2'b00;
    frames(2);
    check("prefreeze_x0", x0(), 102);
    enable = 1'b0;
    frames(5);
    check("freeze_x0", x0(), 102);
    check("freeze_moving0", 32'(moving[0]), 0);
    enable = 1'b1;
    frame(1);
    check("unfreeze_x0", x0(), 103);

    // respawn on a tick edge for channel 1 only
    right = 2'b00;
    @(negedge clk); respawn = 2'b11;
    @(negedge clk); respawn = 2'b00;
    right = 2'b11;
    frames(8);
    check("pre_rsp_x0", x0(), 112);
    check("pre_rsp_x1", x1(), 512);
    @(negedge clk);
    v_tick = 1'b1; respawn = 2'b10;
    @(negedge clk);
    v_tick = 1'b0; respawn = 2'b00;
    check("rsp_tick_x1", x1(), 500);
    check("rsp_tick_moving1", 32'(moving[1]), 0);
    check("rsp_tick_x0", x0(), 115);
    check("rsp_tick_moving0", 32'(moving[0]), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
